mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the combinational ALU in the execute stage. It runs MULT/MULTU/DIV/DIVU over WIDTH+2 cycles using a shared shift-add / shift-subtract datapath and writes MTHI/MTLO in one cycle. A start/busy/done handshake and a cancel input let the pipeline stall on it and flush it on exceptions.

---
 rtl/mdu_iter_pkg.sv | 31 +++
 rtl/mdu_iter_core.sv | 66 ++++++
 rtl/mdu_iter.sv | 155 +++++++++++++++
 tb/tb_mdu_iter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared defines for the iterative multiply/divide unit: op codes, FSM state
// encodings and small op-class helpers.
package mdu_iter_pkg;

   localparam logic [2:0] MDU_OP_NOP   = 3'd0;
   localparam logic [2:0] MDU_OP_MULT  = 3'd1;
   localparam logic [2:0] MDU_OP_MULTU = 3'd2;
   localparam logic [2:0] MDU_OP_DIV   = 3'd3;
   localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
   localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
   localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      MDU_ST_IDLE = 2'd0,
      MDU_ST_RUN  = 2'd1,
      MDU_ST_FIX  = 2'd2
   } mdu_state_t;

   function automatic logic op_is_mul(input logic [2:0] op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
   endfunction

   function automatic logic op_is_div(input logic [2:0] op);
      return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shared iteration datapath: step counter plus 2*WIDTH accumulator doing one
// radix-2 shift-add (multiply) or restoring shift-subtract (divide) per step.
module mdu_iter_core
   import mdu_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               load,
   input  logic               step,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   opa,
   input  logic [WIDTH-1:0]   opb,
   output logic [2*WIDTH-1:0] acc,
   output logic               last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0]      cnt;
   logic               div_q;
   logic [WIDTH-1:0]   opb_q;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_diff;
   logic [2*WIDTH-1:0] acc_nxt;

   assign last = (cnt == CW'(WIDTH - 1));

   // acc = {hi, lo}: multiply keeps the multiplier in lo and shifts the
   // partial product down; divide keeps the dividend in lo and shifts the
   // partial remainder up, quotient bits entering at the bottom.
   always_comb begin
      add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
      sub_diff = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb_q};
      acc_nxt  = acc;
      if (div_q) begin
         if (!sub_diff[WIDTH])
            acc_nxt = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      end else if (acc[0]) begin
         acc_nxt = {add_sum, acc[WIDTH-1:1]};
      end else begin
         acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         div_q <= 1'b0;
         opb_q <= '0;
         acc   <= '0;
      end else if (load) begin
         cnt   <= '0;
         div_q <= div_mode;
         opb_q <= opb;
         acc   <= {{WIDTH{1'b0}}, opa};
      end else if (step) begin
         cnt   <= cnt + 1'b1;
         acc   <= acc_nxt;
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and start/busy/done
// handshake. Define MDU_FAST_MUL_EN for a single-cycle multiply path.
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO write here
//   RUN   | one shift-add / shift-subtract step per cycle
//   FIX   | sign correction, HI/LO update, done next cycle
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_t         state;
   logic [2:0]         op_q;
   logic               neg_res;
   logic               neg_rem;
   logic               div0;
   logic [WIDTH-1:0]   num1_q;

   logic               sgn;
   logic               div_by_zero;
   logic               skip_run;
   logic               accept_md;
   logic               core_step;
   logic               core_last;
   logic [WIDTH-1:0]   mag1;
   logic [WIDTH-1:0]   mag2;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   always_comb begin
      sgn         = op_is_signed(op);
      mag1        = (sgn && num1[WIDTH-1]) ? -num1 : num1;
      mag2        = (sgn && num2[WIDTH-1]) ? -num2 : num2;
      div_by_zero = op_is_div(op) && (num2 == '0);
      accept_md   = (state == MDU_ST_IDLE) && start && !cancel
                    && (op_is_mul(op) || op_is_div(op));
      core_step   = (state == MDU_ST_RUN) && !cancel;
   end

`ifdef MDU_FAST_MUL_EN
   logic [WIDTH-1:0] fast_b;

   assign skip_run = div_by_zero || op_is_mul(op);
   assign prod     = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, fast_b};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         fast_b <= '0;
      else if (accept_md)
         fast_b <= mag2;
   end
`else
   assign skip_run = div_by_zero;
   assign prod     = acc;
`endif

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .resetn   (resetn),
      .load     (accept_md),
      .step     (core_step),
      .div_mode (op_is_div(op)),
      .opa      (mag1),
      .opb      (mag2),
      .acc      (acc),
      .last     (core_last)
   );

   // Divide-by-zero bypasses the magnitude result entirely.
   always_comb begin
      prod_s = neg_res ? -prod : prod;
      fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      if (op_is_mul(op_q)) begin
         fix_hi = prod_s[2*WIDTH-1:WIDTH];
         fix_lo = prod_s[WIDTH-1:0];
      end else if (div0) begin
         fix_hi = num1_q;
         fix_lo = '1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= MDU_ST_IDLE;
         op_q    <= MDU_OP_NOP;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
         num1_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            MDU_ST_IDLE: begin
               if (accept_md) begin
                  op_q    <= op;
                  neg_res <= sgn && (num1[WIDTH-1] ^ num2[WIDTH-1]);
                  neg_rem <= sgn && op_is_div(op) && num1[WIDTH-1];
                  div0    <= div_by_zero;
                  num1_q  <= num1;
                  busy    <= 1'b1;
                  state   <= skip_run ? MDU_ST_FIX : MDU_ST_RUN;
               end else if (start && !cancel && (op == MDU_OP_MTHI)) begin
                  hi <= num1;
               end else if (start && !cancel && (op == MDU_OP_MTLO)) begin
                  lo <= num1;
               end
            end
            MDU_ST_RUN: begin
               if (cancel) begin
                  state <= MDU_ST_IDLE;
                  busy  <= 1'b0;
               end else if (core_last) begin
                  state <= MDU_ST_FIX;
               end
            end
            MDU_ST_FIX: begin
               state <= MDU_ST_IDLE;
               busy  <= 1'b0;
               if (!cancel) begin
                  hi   <= fix_hi;
                  lo   <= fix_lo;
                  done <= 1'b1;
               end
            end
            default: begin
               state <= MDU_ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vectors plus random ops compared
// against a 64-bit arithmetic reference model.
module tb_mdu_iter;

   localparam int W = 32;
   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_RSV   = 3'd7;

`ifdef MDU_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         resetn;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] num1;
   logic [W-1:0] num2;
   logic         cancel;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_chk  = 0;
   int n_pass = 0;

   mdu_iter #(.WIDTH(W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .op     (op),
      .num1   (num1),
      .num2   (num2),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] eh, output logic [W-1:0] el);
      logic [63:0] p;
      longint      sq;
      longint      sr;
      p  = '0;
      eh = '0;
      el = '0;
      case (o)
         OP_MULTU: begin
            p  = {32'b0, a} * {32'b0, b};
            eh = p[63:32];
            el = p[31:0];
         end
         OP_MULT: begin
            p  = longint'($signed(a)) * longint'($signed(b));
            eh = p[63:32];
            el = p[31:0];
         end
         OP_DIVU: begin
            if (b == 0) begin eh = a; el = '1; end
            else begin eh = a % b; el = a / b; end
         end
         OP_DIV: begin
            if (b == 0) begin eh = a; el = '1; end
            else begin
               sq = longint'($signed(a)) / longint'($signed(b));
               sr = longint'($signed(a)) % longint'($signed(b));
               p  = sq;
               el = p[31:0];
               p  = sr;
               eh = p[31:0];
            end
         end
         default: ;
      endcase
   endtask

   // Issues one mul/div op; returns in the done cycle so the next op can
   // start there. The accepting edge is cycle 0; the cycle after it is 1.
   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eh;
      logic [W-1:0] el;
      int           edges;
      int           exp_lat;
      logic         busy_drop;
      ref_model(o, a, b, eh, el);
      if (((o == OP_DIV) || (o == OP_DIVU)) && (b == 0))
         exp_lat = 1;
      else if (FAST && ((o == OP_MULT) || (o == OP_MULTU)))
         exp_lat = 1;
      else
         exp_lat = W + 1;
      start = 1'b1; op = o; num1 = a; num2 = b;
      @(posedge clk); #1;
      start = 1'b0; op = 3'($urandom); num1 = $urandom; num2 = $urandom;
      check({tag, "_busy_acc"}, 64'(busy), 64'd1);
      check({tag, "_done_acc"}, 64'(done), 64'd0);
      edges = 0;
      busy_drop = 1'b0;
      while (!done && edges < W + 10) begin
         if (!busy) busy_drop = 1'b1;
         @(posedge clk); #1;
         edges++;
      end
      check({tag, "_done"},    64'(done), 64'd1);
      check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
      check({tag, "_busy_run"}, 64'(busy_drop), 64'd0);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
   endtask

   task automatic idle_write(input logic [2:0] o, input logic [W-1:0] v, input logic cxl);
      start = 1'b1; op = o; num1 = v; cancel = cxl;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0; num1 = $urandom;
   endtask

   function automatic logic [W-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] save_hi;
      logic [W-1:0] save_lo;
      int           done_seen;
      int           busy_ok;
      resetn = 1'b0; start = 1'b0; op = OP_NOP; num1 = '0; num2 = '0; cancel = 1'b0;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi",   64'(hi),   64'd0);
      check("rst_lo",   64'(lo),   64'd0);
      #10 resetn = 1'b1;
      @(posedge clk); #1;

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7);
      run_op("mult_6m2",  OP_MULT,  32'd6, 32'hFFFF_FFFE);
      run_op("div_m7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2);
      run_op("divu_7_2",  OP_DIVU,  32'd7, 32'd2);
      run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_op("div0_s",    OP_DIV,   32'hFFFF_FF00, 32'd0);
      @(posedge clk); #1;

      // DIVU by zero with a second start held through the FIX cycle
      start = 1'b1; op = OP_DIVU; num1 = 32'h1234; num2 = '0;
      @(posedge clk); #1;
      op = OP_MULTU; num1 = 32'd3; num2 = 32'd5;
      check("div0_busy1", 64'(busy), 64'd1);
      @(posedge clk); #1;
      start = 1'b0;
      check("div0_done", 64'(done), 64'd1);
      check("div0_lo",   64'(lo),   64'hFFFF_FFFF);
      check("div0_hi",   64'(hi),   64'h1234);
      check("div0_ign",  64'(busy), 64'd0);
      @(posedge clk); #1;
      check("div0_ign2", 64'(busy), 64'd0);

      idle_write(OP_MTHI, 32'h1111_1111, 1'b0);
      check("mthi_hi", 64'(hi), 64'h1111_1111);
      check("mthi_done", 64'(done), 64'd0);
      idle_write(OP_MTLO, 32'h2222_2222, 1'b0);
      check("mtlo_lo", 64'(lo), 64'h2222_2222);
      idle_write(OP_MTHI, 32'hDEAD_BEEF, 1'b1);
      check("mthi_cxl", 64'(hi), 64'h1111_1111);
      idle_write(OP_NOP, 32'h5555_5555, 1'b0);
      check("nop_busy", 64'(busy), 64'd0);
      idle_write(OP_RSV, 32'h5555_5555, 1'b0);
      check("rsv_busy", 64'(busy), 64'd0);
      check("rsv_hilo", {32'(hi), 32'(lo)}, {32'h1111_1111, 32'h2222_2222});

      // cancel a DIV in flight: sampled at edge 10, idle in cycle 11
      start = 1'b1; op = OP_DIV; num1 = 32'd1000; num2 = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      check("cxl_busy", 64'(busy), 64'd0);
      check("cxl_done", 64'(done), 64'd0);
      done_seen = 0;
      repeat (W + 4) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      check("cxl_nodone", 64'(done_seen), 64'd0);
      check("cxl_hilo", {32'(hi), 32'(lo)}, {32'h1111_1111, 32'h2222_2222});
      idle_write(OP_MTLO, 32'hA5A5_A5A5, 1'b0);
      check("cxl_mtlo", 64'(lo), 64'hA5A5_A5A5);
      check("cxl_mtlo_done", 64'(done), 64'd0);
      check("cxl_mtlo_busy", 64'(busy), 64'd0);

      // asynchronous reset mid-MULTU
      start = 1'b1; op = OP_MULTU; num1 = 32'h0001_0003; num2 = 32'h0000_0101;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_hilo", {32'(hi), 32'(lo)}, 64'd0);
      #2 resetn = 1'b1;
      done_seen = 0;
      busy_ok = 1;
      repeat (W + 4) begin
         @(posedge clk); #1;
         if (done) done_seen++;
         if (busy) busy_ok = 0;
      end
      check("arst_nodone", 64'(done_seen), 64'd0);
      check("arst_idle", 64'(busy_ok), 64'd1);

      // random mul/div, back-to-back in the done cycle
      for (int i = 0; i < 40; i++) begin
         logic [2:0] o;
         o = 3'($urandom_range(1, 4));
         run_op("rand", o, rand_operand(), rand_operand());
      end
      @(posedge clk); #1;
      check("end_done", 64'(done), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
